isolation_tree_scorer: RTL

- Downstream consumer of the input-buffer FIFO.
- Pops fixed-size feature vectors (NUM_FEATURES consecutive 8-bit samples) from the FIFO.
- Walks one configurable isolation tree, one level per cycle, and emits the path length and an anomaly flag.
- The output uses a valid/ready handshake toward the scoring/aggregation logic.

---
 rtl/isolation_tree_scorer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/isolation_tree_scorer.sv
// Isolation-tree scorer: pops one feature vector from the input FIFO, walks a
// programmable binary tree one level per cycle and reports path length / anomaly.
module isolation_tree_scorer #(
  parameter  int NUM_FEATURES   = 4,
  parameter  int TREE_DEPTH     = 4,
  parameter  int ANOMALY_THRESH = 2,
  localparam int FS_W  = $clog2(NUM_FEATURES),
  localparam int NODES = (1 << TREE_DEPTH) - 1,
  localparam int AW    = $clog2(NODES),
  localparam int PW    = $clog2(TREE_DEPTH),
  localparam int CW    = 1 + FS_W + 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [7:0]    fifo_output,
  input  logic          fifo_empty,
  output logic          read_enable,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [CW-1:0] cfg_data,
  output logic          busy,
  output logic          score_valid,
  input  logic          score_ready,
  output logic [PW-1:0] path_len,
  output logic [AW-1:0] leaf_index,
  output logic          anomaly
);

  typedef enum logic [2:0] {IDLE, POP, CAPTURE, TRAVERSE, OUTPUT} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   node_tbl [NODES];
  logic [7:0]      feat     [NUM_FEATURES];
  logic [FS_W-1:0] sample_cnt;
  logic [AW-1:0]   node;
  logic [PW-1:0]   depth;

  logic [CW-1:0]   cur;
  logic            cur_leaf;
  logic [FS_W-1:0] cur_fs;
  logic [7:0]      cur_thr;
  logic            terminal;
  logic            go_left;

  always_comb begin
    cur      = node_tbl[node];
    cur_leaf = cur[CW-1];
    cur_fs   = cur[CW-2:8];
    cur_thr  = cur[7:0];
    // The bottom level is always a leaf, whatever the table says.
    terminal = cur_leaf || (depth == PW'(TREE_DEPTH - 1));
    go_left  = feat[cur_fs] < cur_thr;
  end

  always_comb begin
    next_state  = state;
    read_enable = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE:     if (enable) next_state = POP;
      POP: begin
        read_enable = !fifo_empty;
        if (!fifo_empty) next_state = CAPTURE;
      end
      CAPTURE:  next_state = (sample_cnt == FS_W'(NUM_FEATURES - 1)) ? TRAVERSE : POP;
      TRAVERSE: if (terminal) next_state = OUTPUT;
      OUTPUT:   if (score_valid && score_ready) next_state = enable ? POP : IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NODES; i++) node_tbl[i] <= '0;
      for (int unsigned i = 0; i < NUM_FEATURES; i++) feat[i] <= '0;
      sample_cnt  <= '0;
      node        <= '0;
      depth       <= '0;
      score_valid <= 1'b0;
      path_len    <= '0;
      leaf_index  <= '0;
      anomaly     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_we && (int'(cfg_addr) < NODES)) node_tbl[cfg_addr] <= cfg_data;
        end
        CAPTURE: begin
          feat[sample_cnt] <= fifo_output;
          sample_cnt       <= sample_cnt + 1'b1;
          if (sample_cnt == FS_W'(NUM_FEATURES - 1)) begin
            node  <= '0;
            depth <= '0;
          end
        end
        TRAVERSE: begin
          if (terminal) begin
            path_len    <= depth;
            leaf_index  <= node;
            anomaly     <= (int'(depth) < ANOMALY_THRESH);
            score_valid <= 1'b1;
          end else begin
            node  <= go_left ? AW'(2 * int'(node) + 1) : AW'(2 * int'(node) + 2);
            depth <= depth + 1'b1;
          end
        end
        OUTPUT: begin
          if (score_ready) score_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
